// File: rtl/awg_ascii_pkg.sv
// awg_ascii_pkg: ASCII constants and FSM state encoding shared by the command parser and reporter
package awg_ascii_pkg;
   localparam logic [7:0] CHAR_F  = 8'h66;
   localparam logic [7:0] CHAR_0  = 8'h30;
   localparam logic [7:0] CHAR_Q  = 8'h3F;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT_ACK, ST_WAIT_DONE, ST_FINISH
   } cmd_state_t;
endpackage

// File: rtl/state_report_tx_if.sv
// state_report_tx_if: byte-wide UART transmit handshake (start strobe, data, busy)
interface state_report_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   modport master (output tx_data, output tx_start, input tx_busy);
   modport slave (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/digit_to_ascii.sv
// digit_to_ascii: maps 1..9 to its ASCII digit and anything else to '?'
module digit_to_ascii
   import awg_ascii_pkg::*;
(
   input  logic [7:0] value,
   output logic [7:0] ascii
);
   // out-of-range values (including 0) are reported as '?' so the host sees them as invalid
   always_comb ascii = (value >= 8'd1 && value <= 8'd9) ? CHAR_0 + value : CHAR_Q;
endmodule

// File: rtl/state_report_tx.sv
// state_report_tx: snapshots waveform settings and sends them as an ASCII "f" + 4 digit report over UART
module state_report_tx
   import awg_ascii_pkg::*;
#(
   parameter bit EOL_EN      = 1'b1,
   parameter bit AUTO_REPORT = 1'b0,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      report_req,
   input  logic [4:0]                state,
   input  logic [7:0]                state_freq,
   input  logic [7:0]                state_amp,
   input  logic [7:0]                state_phase,
   state_report_tx_if.master         tx,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);
   localparam logic [2:0] LAST     = EOL_EN ? 3'd6 : 3'd4;
   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
   cmd_state_t fsm;
   logic [4:0] snap_state;
   logic [7:0] snap_freq, snap_amp, snap_phase;
   logic [7:0] asc_state, asc_freq, asc_amp, asc_phase, cur_byte;
   logic [2:0] idx;
   logic [7:0] cnt;
   logic       pending, start;

   digit_to_ascii u_state (.value({3'b000, snap_state}), .ascii(asc_state));
   digit_to_ascii u_freq  (.value(snap_freq),  .ascii(asc_freq));
   digit_to_ascii u_amp   (.value(snap_amp),   .ascii(asc_amp));
   digit_to_ascii u_phase (.value(snap_phase), .ascii(asc_phase));

   // frame byte selection from the snapshot and the start condition seen in IDLE
   always_comb begin
      cur_byte = idx == 3'd0 ? CHAR_F :
                 idx == 3'd1 ? asc_state :
                 idx == 3'd2 ? asc_freq :
                 idx == 3'd3 ? asc_amp :
                 idx == 3'd4 ? asc_phase :
                 idx == 3'd5 ? CHAR_CR : CHAR_LF;
      start = report_req | pending |
              (AUTO_REPORT & ({state, state_freq, state_amp, state_phase} !=
                              {snap_state, snap_freq, snap_amp, snap_phase}));
   end

   // report sequencer: load snapshot, then per byte start, wait for ack, wait for completion
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm         <= ST_IDLE;
         tx.tx_data  <= 8'h00;
         tx.tx_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         pending     <= 1'b0;
         snap_state  <= 5'd3;
         snap_freq   <= 8'd1;
         snap_amp    <= 8'd1;
         snap_phase  <= 8'd1;
         idx         <= 3'd0;
         cnt         <= 8'd0;
      end else begin
         tx.tx_start <= 1'b0;
         done        <= 1'b0;
         if (fsm != ST_IDLE) pending <= pending | report_req;
         case (fsm)
            ST_IDLE: if (start) begin
               fsm     <= ST_LOAD;
               pending <= 1'b0;
               err     <= 1'b0;
               busy    <= 1'b1;
            end
            ST_LOAD: begin
               snap_state <= state;
               snap_freq  <= state_freq;
               snap_amp   <= state_amp;
               snap_phase <= state_phase;
               idx        <= 3'd0;
               fsm        <= ST_SEND;
            end
            ST_SEND: if (!tx.tx_busy) begin
               tx.tx_data  <= cur_byte;
               tx.tx_start <= 1'b1;
               cnt         <= 8'd0;
               fsm         <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: if (tx.tx_busy) fsm <= ST_WAIT_DONE;
               else if (cnt == ACK_LAST) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
                  fsm  <= ST_IDLE;
               end else cnt <= cnt + 8'd1;
            ST_WAIT_DONE: if (!tx.tx_busy) begin
               if (idx == LAST) begin
                  fsm  <= ST_FINISH;
                  done <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  idx <= idx + 3'd1;
                  fsm <= ST_SEND;
               end
            end
            ST_FINISH: fsm <= ST_IDLE;
            default:   fsm <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_state_report_tx.sv
// tb_state_report_tx: directed checks of report framing, handshake, pending, timeout, reset and auto-report
module tb_state_report_tx;
   logic       clk = 1'b0, rst = 1'b1, req = 1'b0, req_b = 1'b0;
   logic [4:0] st = 5'd3;
   logic [7:0] fr = 8'd1, am = 8'd1, ph = 8'd1;
   logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic       ack_en_a = 1'b1;
   int         checks = 0, errors = 0;
   int         bt_a = 0, bt_b = 0, dones_a = 0, dones_b = 0;
   logic [7:0] q_a[$], q_b[$];

   state_report_tx_if ua ();
   state_report_tx_if ub ();

   state_report_tx dut_a (
      .clk(clk), .rst(rst), .report_req(req), .state(st), .state_freq(fr),
      .state_amp(am), .state_phase(ph), .tx(ua), .busy(busy_a), .done(done_a), .err(err_a));

   state_report_tx #(.EOL_EN(1'b0), .AUTO_REPORT(1'b1)) dut_b (
      .clk(clk), .rst(rst), .report_req(req_b), .state(st), .state_freq(fr),
      .state_amp(am), .state_phase(ph), .tx(ub), .busy(busy_b), .done(done_b), .err(err_b));

   always #5 clk = ~clk;

   // UART model for dut_a: busy rises the cycle after tx_start and stays high 10 cycles
   always @(posedge clk) begin
      if (rst) begin
         ua.tx_busy <= 1'b0;
         bt_a       <= 0;
      end else begin
         if (ua.tx_start) q_a.push_back(ua.tx_data);
         if (ua.tx_start && ack_en_a) begin
            ua.tx_busy <= 1'b1;
            bt_a       <= 10;
         end else if (bt_a == 1) begin
            ua.tx_busy <= 1'b0;
            bt_a       <= 0;
         end else if (bt_a > 1) bt_a <= bt_a - 1;
         if (done_a) dones_a <= dones_a + 1;
      end
   end

   // UART model for dut_b, always acknowledging
   always @(posedge clk) begin
      if (rst) begin
         ub.tx_busy <= 1'b0;
         bt_b       <= 0;
      end else begin
         if (ub.tx_start) q_b.push_back(ub.tx_data);
         if (ub.tx_start) begin
            ub.tx_busy <= 1'b1;
            bt_b       <= 10;
         end else if (bt_b == 1) begin
            ub.tx_busy <= 1'b0;
            bt_b       <= 0;
         end else if (bt_b > 1) bt_b <= bt_b - 1;
         if (done_b) dones_b <= dones_b + 1;
      end
   end

   task automatic pulse_req();
      @(negedge clk) req = 1'b1;
      @(negedge clk) req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 5;
      if (ua.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", ua.tx_data); end
      if (ua.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", ua.tx_start); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
      if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
      if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_a); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_default_frame();
      logic [7:0] exp [7] = '{8'h66, 8'h33, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};
      int d0 = dones_a;
      q_a.delete();
      pulse_req();
      @(negedge clk);
      checks++;
      if (ua.tx_start !== 1'b0) begin errors++; $display("FAIL latency_early: got tx_start %b expected 0", ua.tx_start); end
      @(negedge clk);
      checks++;
      if (ua.tx_start !== 1'b1 || ua.tx_data !== 8'h66) begin errors++; $display("FAIL latency_first: got start %b data %h expected 1 66", ua.tx_start, ua.tx_data); end
      for (int i = 0; i < 400 && dones_a < d0 + 1; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      checks++;
      if (q_a.size() !== 7) begin errors++; $display("FAIL default_len: got %0d expected 7", q_a.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (q_a[i] !== exp[i]) begin errors++; $display("FAIL default_byte%0d: got %h expected %h", i, q_a[i], exp[i]); end
      end
      checks += 3;
      if (dones_a !== d0 + 1) begin errors++; $display("FAIL default_done: got %0d expected %0d", dones_a, d0 + 1); end
      if (err_a !== 1'b0) begin errors++; $display("FAIL default_err: got %b expected 0", err_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL default_busy: got %b expected 0", busy_a); end
   endtask

   task automatic test_invalid_digits();
      logic [7:0] exp [7] = '{8'h66, 8'h3F, 8'h3F, 8'h35, 8'h39, 8'h0D, 8'h0A};
      int da = dones_a, db = dones_b;
      q_a.delete();
      q_b.delete();
      @(negedge clk);
      st = 5'd12; fr = 8'd0; am = 8'd5; ph = 8'd9;
      pulse_req();
      for (int i = 0; i < 400 && (dones_a < da + 1 || dones_b < db + 1); i++) @(negedge clk);
      repeat (20) @(negedge clk);
      checks += 2;
      if (q_a.size() !== 7) begin errors++; $display("FAIL invalid_len: got %0d expected 7", q_a.size()); end
      if (q_b.size() !== 5) begin errors++; $display("FAIL noeol_len: got %0d expected 5", q_b.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (q_a[i] !== exp[i]) begin errors++; $display("FAIL invalid_byte%0d: got %h expected %h", i, q_a[i], exp[i]); end
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (q_b[i] !== exp[i]) begin errors++; $display("FAIL noeol_byte%0d: got %h expected %h", i, q_b[i], exp[i]); end
      end
   endtask

   task automatic test_pending();
      logic [7:0] exp [14] = '{8'h66, 8'h3F, 8'h3F, 8'h35, 8'h39, 8'h0D, 8'h0A,
                               8'h66, 8'h32, 8'h34, 8'h36, 8'h38, 8'h0D, 8'h0A};
      int d0 = dones_a;
      q_a.delete();
      pulse_req();
      repeat (3) @(negedge clk);
      req = 1'b1;
      st = 5'd2; fr = 8'd4; am = 8'd6; ph = 8'd8;
      @(negedge clk) req = 1'b0;
      repeat (30) @(negedge clk);
      pulse_req();
      for (int i = 0; i < 800 && dones_a < d0 + 2; i++) @(negedge clk);
      repeat (150) @(negedge clk);
      checks += 2;
      if (dones_a !== d0 + 2) begin errors++; $display("FAIL pending_frames: got %0d expected %0d", dones_a - d0, 2); end
      if (q_a.size() !== 14) begin errors++; $display("FAIL pending_len: got %0d expected 14", q_a.size()); end
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (q_a[i] !== exp[i]) begin errors++; $display("FAIL pending_byte%0d: got %h expected %h", i, q_a[i], exp[i]); end
      end
   endtask

   task automatic test_timeout();
      logic [7:0] exp [7] = '{8'h66, 8'h32, 8'h34, 8'h36, 8'h38, 8'h0D, 8'h0A};
      int d0 = dones_a;
      ack_en_a = 1'b0;
      q_a.delete();
      pulse_req();
      repeat (17) @(negedge clk);
      checks += 2;
      if (err_a !== 1'b0) begin errors++; $display("FAIL timeout_early_err: got %b expected 0", err_a); end
      if (busy_a !== 1'b1) begin errors++; $display("FAIL timeout_early_busy: got %b expected 1", busy_a); end
      @(negedge clk);
      checks += 2;
      if (err_a !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", err_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy_a); end
      repeat (10) @(negedge clk);
      checks += 2;
      if (dones_a !== d0) begin errors++; $display("FAIL timeout_done: got %0d expected %0d", dones_a, d0); end
      if (err_a !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", err_a); end
      ack_en_a = 1'b1;
      q_a.delete();
      pulse_req();
      checks++;
      if (err_a !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", err_a); end
      for (int i = 0; i < 400 && dones_a < d0 + 1; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      checks++;
      if (q_a.size() !== 7) begin errors++; $display("FAIL retry_len: got %0d expected 7", q_a.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (q_a[i] !== exp[i]) begin errors++; $display("FAIL retry_byte%0d: got %h expected %h", i, q_a[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      q_a.delete();
      pulse_req();
      for (int i = 0; i < 300 && q_a.size() < 4; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks += 4;
      if (ua.tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data: got %h expected 00", ua.tx_data); end
      if (ua.tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start: got %b expected 0", ua.tx_start); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
      if (done_a !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done_a); end
      rst = 1'b0;
      repeat (60) @(negedge clk);
      checks++;
      if (q_a.size() !== 4) begin errors++; $display("FAIL midrst_quiet: got %0d bytes expected 4", q_a.size()); end
   endtask

   task automatic test_auto_report();
      logic [7:0] exp [5] = '{8'h66, 8'h33, 8'h31, 8'h37, 8'h31};
      int d0;
      @(negedge clk);
      st = 5'd3; fr = 8'd1; am = 8'd1; ph = 8'd1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q_b.delete();
      d0 = dones_b;
      repeat (10) @(negedge clk);
      checks += 2;
      if (q_b.size() !== 0) begin errors++; $display("FAIL auto_quiet: got %0d bytes expected 0", q_b.size()); end
      if (busy_b !== 1'b0) begin errors++; $display("FAIL auto_idle_busy: got %b expected 0", busy_b); end
      am = 8'd7;
      for (int i = 0; i < 300 && dones_b < d0 + 1; i++) @(negedge clk);
      repeat (100) @(negedge clk);
      checks += 2;
      if (dones_b !== d0 + 1) begin errors++; $display("FAIL auto_frames: got %0d expected 1", dones_b - d0); end
      if (q_b.size() !== 5) begin errors++; $display("FAIL auto_len: got %0d expected 5", q_b.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (q_b[i] !== exp[i]) begin errors++; $display("FAIL auto_byte%0d: got %h expected %h", i, q_b[i], exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_default_frame();
      test_invalid_digits();
      test_pending();
      test_timeout();
      test_reset_mid_frame();
      test_auto_report();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
